// File: rtl/stream_demux_router.sv
// One-producer, N_CH-consumer stream router with a one-entry register per channel.
// Supports unicast by in_sel, all-or-nothing broadcast, and counting of out-of-range drops.
module stream_demux_router #(
   parameter int DATA_W = 4,
   parameter int N_CH   = 4,
   parameter int SEL_W  = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [DATA_W-1:0]        in_data,
   input  logic [SEL_W-1:0]         in_sel,
   input  logic                     in_bcast,
   output logic [N_CH-1:0]          out_valid,
   input  logic [N_CH-1:0]          out_ready,
   output logic [N_CH*DATA_W-1:0]   out_data,
   output logic [7:0]               drop_cnt
);

   // Valid/ready: a word moves on any edge where valid and ready are both high;
   // the sender holds its payload stable while valid is high and ready is low.

   localparam logic [SEL_W:0] NCH_CMP = (SEL_W+1)'(N_CH);

   logic [N_CH-1:0]              valid_q, valid_d;
   logic [N_CH-1:0][DATA_W-1:0]  data_q, data_d;
   logic [7:0]                   cnt_q, cnt_d;

   logic [N_CH-1:0]              free;
   logic [N_CH-1:0]              load;
   logic                         sel_in_range;
   logic                         sel_free;
   logic                         in_ready_c;
   logic                         accept;
   logic                         drop;

   // Slot selection and acceptance. sel_free is built by compare rather than
   // indexing so an out-of-range in_sel never indexes past the slot vector.
   always_comb begin
      free         = ~valid_q | out_ready;
      sel_in_range = ({1'b0, in_sel} < NCH_CMP);
      sel_free     = 1'b0;
      for (int k = 0; k < N_CH; k++) begin
         if (in_sel == SEL_W'(k)) begin
            sel_free = free[k];
         end
      end

      if (in_bcast) begin
         in_ready_c = &free;
      end else if (sel_in_range) begin
         in_ready_c = sel_free;
      end else begin
         in_ready_c = 1'b1;
      end

      accept = in_valid & in_ready_c;
      drop   = accept & ~in_bcast & ~sel_in_range;

      load = '0;
      for (int k = 0; k < N_CH; k++) begin
         load[k] = accept & (in_bcast | (sel_in_range & (in_sel == SEL_W'(k))));
      end
   end

   // Per-slot next state: a fill wins over a drain, and a drained slot reads zero.
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      for (int k = 0; k < N_CH; k++) begin
         if (load[k]) begin
            valid_d[k] = 1'b1;
            data_d[k]  = in_data;
         end else if (valid_q[k] && out_ready[k]) begin
            valid_d[k] = 1'b0;
            data_d[k]  = '0;
         end
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (drop && (cnt_q != 8'hFF)) begin
         cnt_d = cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= '0;
         data_q  <= '0;
         cnt_q   <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
      end
   end

   assign in_ready  = in_ready_c;
   assign out_valid = valid_q;
   assign out_data  = data_q;
   assign drop_cnt  = cnt_q;

endmodule
